// File: rtl/mem_block_pkg.sv
// Shared geometry defaults and the depth helper for the mem_block RAM.
package mem_block_pkg;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 3;

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/mem_block_if.sv
// Access bus of mem_block: one shared address, write data/enable, registered read data.
interface mem_block_if
    import mem_block_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    // No handshake: every rising edge samples addr/cin/we, and cout always
    // reflects the word addressed at the previous edge.
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] cin;
    logic              we;
    logic [DATA_W-1:0] cout;

    modport master (output addr, output cin, output we, input cout);
    modport slave  (input addr, input cin, input we, output cout);

endinterface

// File: rtl/mem_block_rdmux.sv
// Combinational DEPTH:1 word select feeding the mem_block read register.
module mem_block_rdmux
    import mem_block_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = depth(ADDR_W)
) (
    input  logic [DATA_W-1:0] words [DEPTH],
    input  logic [ADDR_W-1:0] sel,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = words[sel];
    end

endmodule

// File: rtl/mem_block.sv
// Single-port synchronous RAM, registered read with 1-cycle latency.
// Read-first by default; define MEM_WRITE_THROUGH_EN for write-first behaviour.
module mem_block
    import mem_block_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic         clk,
    input logic         rst,
    mem_block_if.slave  bus
);

    localparam int DEPTH = depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] cout_q;

    mem_block_rdmux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rdmux (
        .words (mem),
        .sel   (bus.addr),
        .rdata (rd_word)
    );

    // Reset wins over we, so a write presented in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            cout_q <= '0;
        end else begin
            if (bus.we) begin
                mem[bus.addr] <= bus.cin;
            end
`ifdef MEM_WRITE_THROUGH_EN
            cout_q <= bus.we ? bus.cin : rd_word;
`else
            cout_q <= rd_word;
`endif
        end
    end

    assign bus.cout = cout_q;

endmodule

// File: tb/tb_mem_block.sv
// Self-checking bench for mem_block: directed scenarios then random traffic
// compared against a word-array reference model.
module tb_mem_block;

    localparam int AW    = 2;
    localparam int DW    = 3;
    localparam int DEPTH = 4;
`ifdef MEM_WRITE_THROUGH_EN
    localparam bit WRITE_FIRST = 1'b1;
`else
    localparam bit WRITE_FIRST = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_block_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_block #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // reference model and scoreboard
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_cout;
    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_fails  = 0;

    // Apply one cycle of stimulus, advance the model by the RAM rules, then
    // compare cout shortly after the edge.
    task automatic cyc(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input string tag);
        logic [DW-1:0] exp;
        logic [DW-1:0] got;
        rst      = r;
        bus.we   = w;
        bus.addr = a;
        bus.cin  = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            ref_cout = '0;
        end else begin
            ref_cout = (w && WRITE_FIRST) ? d : ref_mem[a];
            if (w) ref_mem[a] = d;
        end
        exp_q.push_back(ref_cout);
        #1;
        exp = exp_q.pop_front();
        got = bus.cout;
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: cout=%b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.cin = '0;

        // 1: reset, then read every address
        cyc(1'b1, 1'b0, 2'd0, 3'b000, "reset");
        for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b0, a[AW-1:0], 3'b000, "post_reset_read");

        // 2/3: hold a write to addr 1
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 2'd1, 3'b110, "held_write");

        // 4: fill then read back
        for (int a = 0; a < DEPTH; a++) begin
            logic [DW-1:0] v;
            v = DW'(a + 1);
            cyc(1'b0, 1'b1, a[AW-1:0], v, "fill");
        end
        for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b0, a[AW-1:0], 3'b000, "readback");

        // 5: reset with a concurrent write, then read all
        cyc(1'b1, 1'b1, 2'd2, 3'b111, "reset_with_we");
        for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b0, a[AW-1:0], 3'b000, "cleared_read");

        // 6: we=0 with toggling cin must not disturb mem[3]
        cyc(1'b0, 1'b1, 2'd3, 3'b011, "seed_addr3");
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 2'd3, (k % 2 == 0) ? 3'b101 : 3'b010, "no_write_hold");

        // random traffic with occasional reset
        for (int k = 0; k < 200; k++) begin
            logic r;
            r = ($urandom_range(0, 19) == 0);
            cyc(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                DW'($urandom_range(0, (1 << DW) - 1)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
